// File: rtl/iq_sample_pacer_pkg.sv
// Shared constants for the I/Q sample pacer and the sample-rate file writer.
package iq_sample_pacer_pkg;

  localparam int DEF_BITS    = 16;
  localparam int DEF_COLUMNS = 2;
  localparam int DEF_DEPTH   = 16;
  localparam int CLK_HZ      = 100_000_000;
  localparam int SAMPLE_HZ   = 6400;

  // Clocks per sample period; the writer and the pacer must agree on this.
  function automatic int clk_div_of(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

  localparam int DEF_CLK_DIV = clk_div_of(CLK_HZ, SAMPLE_HZ);

endpackage

// File: rtl/iq_sample_pacer_fifo.sv
// Small synchronous FIFO with an extra pointer bit to tell full from empty.
module sync_fifo
  import iq_sample_pacer_pkg::*;
#(
  parameter int WIDTH = DEF_BITS * DEF_COLUMNS,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Guard against pushing into a full or popping from an empty FIFO.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; both may advance in the same cycle, leaving level unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/iq_sample_pacer.sv
// Releases one buffered I/Q word per sample period and holds it stable
// until the next period, so a sample-rate writer can latch it anytime.
module iq_sample_pacer
  import iq_sample_pacer_pkg::*;
#(
  parameter int BITS    = DEF_BITS,
  parameter int COLUMNS = DEF_COLUMNS,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [BITS*COLUMNS-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [BITS*COLUMNS-1:0]   data,
  output logic                      sample_strobe,
  output logic [$clog2(DEPTH):0]    level,
  output logic [15:0]               underflow_cnt
);

  localparam int W  = BITS * COLUMNS;
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = {{(DW-1){1'b0}}, 1'b1};

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [W-1:0]  head;

  assign tick     = enable && (div_cnt == DIV_LAST);
  // Ready depends only on stored state; no bypass when a pop coincides with full.
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = tick && !empty;

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // Sample-period divider: held at zero while disabled, wraps after terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= {DW{1'b0}};
    end else if (!enable || tick) begin
      div_cnt <= {DW{1'b0}};
    end else begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  // Output register, strobe and saturating underflow count, all updated per tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data          <= {W{1'b0}};
      sample_strobe <= 1'b0;
      underflow_cnt <= 16'h0000;
    end else begin
      sample_strobe <= pop;
      if (pop) data <= head;
      if (tick && empty && (underflow_cnt != 16'hFFFF)) begin
        underflow_cnt <= underflow_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_iq_sample_pacer.sv
// Randomized and directed bench for iq_sample_pacer against a queue-based model.
module tb_iq_sample_pacer;

  localparam int BITS    = 16;
  localparam int COLUMNS = 2;
  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int W       = BITS * COLUMNS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  data;
  logic          sample_strobe;
  logic [2:0]    level;
  logic [15:0]   underflow_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: a word queue, a count of enabled cycles into the
  // current period, the held output word, the strobe and the underflow count.
  logic [W-1:0] m_q [$];
  int           m_run;
  logic [W-1:0] m_data;
  logic         m_strobe;
  int           m_under;

  iq_sample_pacer #(
    .BITS    (BITS),
    .COLUMNS (COLUMNS),
    .CLK_DIV (CLK_DIV),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data          (data),
    .sample_strobe (sample_strobe),
    .level         (level),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_run    = 0;
    m_data   = '0;
    m_strobe = 1'b0;
    m_under  = 0;
  endtask

  // One clock: apply inputs (we are just past a falling edge), advance the
  // model across the rising edge, then compare every output.
  task automatic cycle(input logic en, input logic vld, input logic [W-1:0] w);
    bit ready;
    bit tick;
    enable   = en;
    in_valid = vld;
    in_data  = w;
    ready = (m_q.size() < DEPTH);
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, ready});
    tick  = en && ((m_run + 1) % CLK_DIV == 0);
    m_run = en ? (m_run + 1) % CLK_DIV : 0;
    m_strobe = 1'b0;
    if (tick) begin
      if (m_q.size() > 0) begin
        m_data   = m_q.pop_front();
        m_strobe = 1'b1;
      end else if (m_under < 16'hFFFF) begin
        m_under++;
      end
    end
    if (vld && ready) m_q.push_back(w);
    @(posedge clk);
    #1;
    check("data", data, m_data);
    check("strobe", {31'd0, sample_strobe}, {31'd0, m_strobe});
    check("level", {29'd0, level}, m_q.size());
    check("underflow", {16'd0, underflow_cnt}, m_under);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    enable   = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();
    check("rst_data", data, 32'h0);
    check("rst_level", {29'd0, level}, 32'd0);
    check("rst_under", {16'd0, underflow_cnt}, 32'd0);

    // 1: basic pacing, three words, pops on ticks at cycles 4, 8, 12
    cycle(1'b1, 1'b1, 32'h0001_0002);
    cycle(1'b1, 1'b1, 32'h0003_0004);
    cycle(1'b1, 1'b1, 32'h0005_0006);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, '0);
    check("t1_data", data, 32'h0005_0006);
    check("t1_under", {16'd0, underflow_cnt}, 32'd0);

    // 3: underflow for three empty periods, then a fresh word
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, '0);
    check("t3_hold", data, 32'h0005_0006);
    check("t3_under", {16'd0, underflow_cnt}, 32'd3);
    cycle(1'b1, 1'b1, 32'hAAAA_5555);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
    check("t3_data", data, 32'hAAAA_5555);
    check("t3_under2", {16'd0, underflow_cnt}, 32'd3);

    // 4: push in the same cycle as an empty-FIFO tick
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'hC0DE_BEEF);
    check("t4_under", {16'd0, underflow_cnt}, 32'd4);
    check("t4_level", {29'd0, level}, 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, '0);
    check("t4_data", data, 32'hC0DE_BEEF);

    // 2: fill with the divider stopped, then one pop frees one slot
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 32'h0000_0100 + i);
    check("t2_level", {29'd0, level}, 32'd4);
    check("t2_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 32'h0000_0200 + i);
    check("t2_data", data, 32'h0000_0100);

    // 5: asynchronous reset between edges with level=2
    do_reset();
    cycle(1'b1, 1'b1, 32'h1234_5678);
    cycle(1'b1, 1'b1, 32'h1111_2222);
    cycle(1'b1, 1'b1, 32'h3333_4444);
    cycle(1'b1, 1'b0, '0);
    check("t5_pre_data", data, 32'h1234_5678);
    check("t5_pre_level", {29'd0, level}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("t5_data", data, 32'h0);
    check("t5_level", {29'd0, level}, 32'd0);
    check("t5_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h0BAD_F00D);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0);

    // 6: saturation of the underflow counter
    force dut.underflow_cnt = 16'hFFFE;
    #1;
    release dut.underflow_cnt;
    m_under = 16'hFFFE;
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, '0);
    check("t6_sat", {16'd0, underflow_cnt}, 32'h0000_FFFF);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iq_sample_pacer.md
Name: iq_sample_pacer

Overview:
Rate-pacing output stage between the GMSK modulator datapath and the file-dump bench writer. It accepts multi-column (I/Q) sample words on a valid/ready stream and buffers them in a small FIFO. It releases exactly one word per sample period, derived from the system clock by an integer divider. The held output bus stays stable for a full sample period, so a sample-rate file writer can latch it at any point in the period.

Parameters:
BITS, 16, width of one column (one signed sample)
COLUMNS, 2, columns per word; column j occupies bits [BITS*j +: BITS]
CLK_DIV, 15625, clocks per sample period (100 MHz / 6400 Sa/s); legal range >= 2
DEPTH, 16, FIFO depth in words; power of 2, >= 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
enable  in  1  runs the sample-period divider
in_data  in  BITS*COLUMNS  input sample word
in_valid  in  1  in_data valid
in_ready  out  1  FIFO can accept a word
data  out  BITS*COLUMNS  held output word; column packing unchanged from in_data
sample_strobe  out  1  one-cycle pulse, coincident with the new value on data
level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
underflow_cnt  out  16  periods with no word available; saturates at 16'hFFFF

Behaviour:
- Reset (asynchronous assert, synchronous release) forces data=0, sample_strobe=0, level=0, underflow_cnt=0, divider=0, FIFO empty. in_ready=0 while rst is high.
- Divider:
  - Counts 0..CLK_DIV-1 while enable=1 and wraps to 0.
  - Terminal count (CLK_DIV-1) raises the internal tick.
  - enable=0 holds the divider at 0 and suppresses ticks. Re-enabling gives the first tick CLK_DIV cycles later.
- Push: occurs when in_valid && in_ready at a clock edge.
  - in_ready = !full (level != DEPTH). It is purely registered-state based and does not depend on in_valid.
  - When full, in_ready=0, even if a pop happens in the same cycle. There is no full-bypass.
- Tick with FIFO non-empty:
  - At the edge after the tick, data <= FIFO head, head pops, sample_strobe=1 for that one cycle.
  - Latency from the terminal-count cycle to the data update is 1 clock.
- Tick with FIFO empty:
  - data holds its previous value and sample_strobe stays 0.
  - underflow_cnt increments, saturating at 16'hFFFF.
  - A push in the same cycle is not bypassed. The tick still counts as an underflow and the word is stored.
- Simultaneous push and pop: level unchanged and both pointers advance.
- Read and write pointers wrap modulo DEPTH. An extra pointer bit distinguishes full from empty.
- data changes only on a strobe cycle. Between strobes it is constant; this is the property the writer relies on.
- Reset mid-period or with the FIFO partially full discards all content immediately. data returns to 0.
- No arithmetic is performed on samples. Column order and bit order pass through untouched.

Decomposition:
- Shared package constants: default BITS/COLUMNS, the sample-rate and clock-frequency constants, and a function giving CLK_DIV = CLK_HZ / SAMPLE_HZ. The bench writer and this block use the same values.
- Sub-module sync_fifo(WIDTH, DEPTH) provides push/pop/full/empty/level. The pacer itself holds only the divider, the output register and the underflow counter.

Test Plan:
Test configuration: CLK_DIV=4, DEPTH=4, BITS=16, COLUMNS=2, enable=1 after reset.
1. Basic pacing: push words 32'h0001_0002, 32'h0003_0004, 32'h0005_0006 back-to-back.
   -> data takes each value in order on successive strobes, spaced exactly 4 clocks apart; level goes 3->2->1->0; underflow_cnt=0.
2. Fill and backpressure: hold in_valid=1 with an incrementing word and no tick (enable=0).
   -> in_ready drops after the 4th push; level=4; the 5th word is not accepted until enable=1 and one strobe pops, after which in_ready returns high for one push.
3. Underflow: after the FIFO drains, leave in_valid=0 for 3 periods.
   -> data holds the last word, no strobe fires, underflow_cnt=3. Push 32'hAAAA_5555: the next tick outputs it and underflow_cnt stays 3.
4. Simultaneous push on an empty-FIFO tick:
   -> underflow_cnt increments by 1; the word appears on data at the following tick, 4 clocks later.
5. Asynchronous reset mid-operation: assert rst between clock edges with level=2 and data=32'h1234_5678.
   -> data=0, level=0, in_ready=0 immediately, without waiting for a clock edge. After release the first strobe occurs only after a new push and CLK_DIV clocks.
6. Underflow saturation (bench forces the counter to 16'hFFFE): two empty ticks.
   -> underflow_cnt reads 16'hFFFF and does not wrap.
